// File: rtl/instruction_encoder.sv
// instruction_encoder: encodes R/I/B/J/JALR requests into RV32I words behind a 2-entry output FIFO.
// Optional macro IMM_RANGE_CHECK_EN flags out-of-range or misaligned immediates as illegal.
module instruction_encoder (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inValid,
    output logic        inReady,
    input  logic [2:0]  format,
    input  logic [3:0]  opALU,
    input  logic [2:0]  branchT,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] immediateValue,
    output logic [31:0] instruction,
    output logic        outValid,
    input  logic        outReady,
    output logic        outError,
    output logic [7:0]  wordIndex,
    output logic [7:0]  errorCount
);
    typedef struct packed {
        logic [31:0] word;
        logic        err;
        logic [7:0]  idx;
    } entryT;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [2:0]  fun3;
    logic [6:0]  fun7;
    logic        isShift, aluBad, iBad, shiftBad, bBad, jBad, newErr;
    logic [11:0] immI;
    logic [31:0] newWord;
    entryT       mem [2];
    logic        rdPtr, wrPtr, push, pop;
    logic [1:0]  count;
    logic [7:0]  seq, errCnt;

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm     = immediateValue;
    assign iBad     = simm < -2048 || simm > 2047;
    assign shiftBad = immediateValue[31:5] != '0;
    assign bBad     = simm < -4096 || simm > 4094 || immediateValue[0];
    assign jBad     = simm < -1048576 || simm > 1048574 || immediateValue[0];
`else
    logic unusedImmBits;
    assign unusedImmBits = ^immediateValue[31:21];
    assign iBad     = 1'b0;
    assign shiftBad = 1'b0;
    assign bBad     = 1'b0;
    assign jBad     = 1'b0;
`endif

    always_comb begin
        case (opALU)
            4'd2:       fun3 = 3'b111;
            4'd3:       fun3 = 3'b110;
            4'd4:       fun3 = 3'b100;
            4'd5:       fun3 = 3'b010;
            4'd6:       fun3 = 3'b011;
            4'd7:       fun3 = 3'b001;
            4'd8, 4'd9: fun3 = 3'b101;
            default:    fun3 = 3'b000;
        endcase
        fun7    = (opALU == 4'd1 || opALU == 4'd9) ? 7'b0100000 : 7'b0000000;
        isShift = opALU >= 4'd7 && opALU <= 4'd9;
        aluBad  = opALU > 4'd9;
        // Shift immediates carry fun7 in their upper bits
        immI    = isShift ? {fun7, immediateValue[4:0]} : immediateValue[11:0];
        newErr  = 1'b1;
        newWord = NOP;
        case (format)
            3'd0: begin
                newErr  = aluBad;
                newWord = {fun7, rs2, rs1, fun3, rd, 7'b0110011};
            end
            3'd1: begin
                newErr  = aluBad || opALU == 4'd1 || (isShift ? shiftBad : iBad);
                newWord = {immI, rs1, fun3, rd, 7'b0010011};
            end
            3'd2: begin
                newErr  = branchT == 3'd2 || branchT == 3'd3 || bBad;
                newWord = {immediateValue[12], immediateValue[10:5], rs2, rs1, branchT,
                           immediateValue[4:1], immediateValue[11], 7'b1100011};
            end
            3'd3: begin
                newErr  = jBad;
                newWord = {immediateValue[20], immediateValue[10:1], immediateValue[11],
                           immediateValue[19:12], rd, 7'b1101111};
            end
            3'd4: begin
                newErr  = iBad;
                newWord = {immediateValue[11:0], rs1, 3'b000, rd, 7'b1100111};
            end
            default: newErr = 1'b1;
        endcase
        if (newErr) newWord = NOP;
    end

    assign inReady    = !count[1];
    assign outValid   = count != 2'd0;
    assign push       = inValid && inReady;
    assign pop        = outValid && outReady;
    assign instruction = mem[rdPtr].word;
    assign outError   = mem[rdPtr].err;
    assign wordIndex  = mem[rdPtr].idx;
    assign errorCount = errCnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rdPtr  <= 1'b0;
            wrPtr  <= 1'b0;
            count  <= 2'd0;
            seq    <= 8'd0;
            errCnt <= 8'd0;
        end else begin
            if (push) begin
                mem[wrPtr] <= '{word: newWord, err: newErr, idx: seq};
                wrPtr      <= ~wrPtr;
                seq        <= seq + 8'd1;
                if (newErr && errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
            end
            if (pop) rdPtr <= ~rdPtr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: vector table plus back-pressure, reset and saturation sequences, checked through a scoreboard queue.
module tb_instruction_encoder;
    logic        clk = 1'b0, rstn = 1'b0, inValid = 1'b0, outReady = 1'b1;
    logic [2:0]  format = '0, branchT = '0;
    logic [3:0]  opALU = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] immediateValue = '0, instruction;
    logic        inReady, outValid, outError;
    logic [7:0]  wordIndex, errorCount;

    typedef struct {
        logic [2:0]  fmt;
        logic [3:0]  alu;
        logic [2:0]  br;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] expWord;
        logic        expErr;
    } vecT;

    typedef struct {
        logic [31:0] word;
        logic        err;
        logic [7:0]  idx;
    } expT;

    expT        sb[$];
    int         compared = 0, mismatched = 0;
    logic [7:0] nextIdx = 8'd0, expErrCnt = 8'd0;

    instruction_encoder dut (
        .clk(clk), .rstn(rstn), .inValid(inValid), .inReady(inReady), .format(format),
        .opALU(opALU), .branchT(branchT), .rd(rd), .rs1(rs1), .rs2(rs2),
        .immediateValue(immediateValue), .instruction(instruction), .outValid(outValid),
        .outReady(outReady), .outError(outError), .wordIndex(wordIndex), .errorCount(errorCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vecT mk(input logic [2:0] f, input logic [3:0] a, input logic [2:0] b,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [31:0] imm, input logic [31:0] w, input logic e);
        vecT v;
        v.fmt = f; v.alu = a; v.br = b; v.rd = d; v.rs1 = s1; v.rs2 = s2;
        v.imm = imm; v.expWord = w; v.expErr = e;
        return v;
    endfunction

    always @(negedge clk) begin
        expT e;
        if (rstn && outValid && outReady) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected word: got %h, expected none", instruction);
            end else begin
                e = sb.pop_front();
                check("word", instruction, e.word);
                check("outError", {31'b0, outError}, {31'b0, e.err});
                check("wordIndex", {24'b0, wordIndex}, {24'b0, e.idx});
            end
        end
    end

    task automatic drive(input vecT v);
        format = v.fmt; opALU = v.alu; branchT = v.br;
        rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; immediateValue = v.imm;
    endtask

    task automatic accept(input vecT v);
        sb.push_back('{v.expWord, v.expErr, nextIdx});
        nextIdx++;
        if (v.expErr && expErrCnt != 8'hFF) expErrCnt++;
    endtask

    task automatic send(input vecT v);
        bit done = 0;
        drive(v);
        inValid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (inReady) begin
                accept(v);
                done = 1;
            end
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL accept timeout: got inReady=0, expected 1");
        end
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
        check("drained", sb.size(), 0);
        @(posedge clk); #1;
        check("outValid idle", {31'b0, outValid}, 0);
    endtask

    task automatic resetPulse();
        rstn = 1'b0;
        sb.delete();
        nextIdx = 8'd0;
        expErrCnt = 8'd0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecT  tbl[17];
        vecT  v;
        logic [31:0] held;
        bit   done;
        tbl[0]  = mk(0, 0,  0, 1, 2, 3, 32'd0,        32'h003100B3, 0);
        tbl[1]  = mk(0, 1,  0, 3, 1, 2, 32'd0,        32'h402081B3, 0);
        tbl[2]  = mk(0, 2,  0, 1, 1, 1, 32'd0,        32'h0010F0B3, 0);
        tbl[3]  = mk(0, 10, 0, 1, 1, 1, 32'd0,        32'h00000013, 1);
        tbl[4]  = mk(1, 0,  0, 5, 0, 0, 32'hFFFFFFFF, 32'hFFF00293, 0);
        tbl[5]  = mk(1, 1,  0, 1, 1, 0, 32'd5,        32'h00000013, 1);
        tbl[6]  = mk(1, 9,  0, 1, 1, 0, 32'd3,        32'h4030D093, 0);
        tbl[7]  = mk(1, 4,  0, 2, 3, 0, 32'h7FF,      32'h7FF1C113, 0);
        tbl[8]  = mk(4, 0,  0, 1, 5, 0, 32'd4,        32'h004280E7, 0);
        tbl[9]  = mk(2, 0,  0, 0, 1, 2, 32'd8,        32'h00208463, 0);
        tbl[10] = mk(2, 0,  2, 0, 1, 2, 32'd8,        32'h00000013, 1);
        tbl[11] = mk(2, 0,  1, 0, 0, 0, 32'hFFFFFFFC, 32'hFE001EE3, 0);
        tbl[12] = mk(3, 0,  0, 1, 0, 0, 32'd2048,     32'h001000EF, 0);
        tbl[13] = mk(3, 0,  0, 0, 0, 0, 32'hFFFFFFFE, 32'hFFFFF06F, 0);
        tbl[14] = mk(6, 0,  0, 1, 1, 1, 32'd0,        32'h00000013, 1);
`ifdef IMM_RANGE_CHECK_EN
        tbl[15] = mk(1, 0,  0, 0, 0, 0, 32'd2048,     32'h00000013, 1);
        tbl[16] = mk(1, 8,  0, 1, 1, 0, 32'd32,       32'h00000013, 1);
`else
        tbl[15] = mk(1, 0,  0, 0, 0, 0, 32'd2048,     32'h80000013, 0);
        tbl[16] = mk(1, 8,  0, 1, 1, 0, 32'd32,       32'h0000D093, 0);
`endif

        #2;
        check("reset outValid", {31'b0, outValid}, 0);
        check("reset inReady", {31'b0, inReady}, 1);
        check("reset instruction", instruction, 0);
        check("reset outError", {31'b0, outError}, 0);
        check("reset wordIndex", {24'b0, wordIndex}, 0);
        check("reset errorCount", {24'b0, errorCount}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int i = 0; i < 17; i++) send(tbl[i]);
        drain();
        check("table errorCount", {24'b0, errorCount}, {24'b0, expErrCnt});

        // Back-pressure: third request must wait for a slot
        resetPulse();
        outReady = 1'b0;
        v = mk(0, 0, 0, 0, 2, 3, 32'd0, 32'h0, 0);
        for (int c = 0; c < 3; c++) begin
            v.rd = 5'(c + 1);
            v.expWord = 32'h00310033 | (32'(c + 1) << 7);
            drive(v);
            inValid = 1'b1;
            @(negedge clk);
            check($sformatf("inReady cycle %0d", c), {31'b0, inReady}, {31'b0, c < 2});
            if (inReady) accept(v);
            @(posedge clk); #1;
        end
        @(negedge clk);
        held = instruction;
        @(negedge clk);
        check("stall hold", instruction, held);
        check("stall outValid", {31'b0, outValid}, 1);
        check("stall head index", {24'b0, wordIndex}, 0);
        @(posedge clk); #1;
        outReady = 1'b1;
        done = 0;
        for (int t = 0; t < 10 && !done; t++) begin
            @(negedge clk);
            if (inReady) begin
                accept(v);
                done = 1;
            end
        end
        check("third accepted", {31'b0, done}, 1);
        @(posedge clk); #1;
        inValid = 1'b0;
        drain();

        // Reset with two words queued
        outReady = 1'b0;
        send(tbl[0]);
        send(tbl[3]);
        check("queued full", {31'b0, inReady}, 0);
        #2;
        rstn = 1'b0;
        sb.delete();
        nextIdx = 8'd0;
        expErrCnt = 8'd0;
        #1;
        check("midreset outValid", {31'b0, outValid}, 0);
        check("midreset inReady", {31'b0, inReady}, 1);
        check("midreset wordIndex", {24'b0, wordIndex}, 0);
        check("midreset errorCount", {24'b0, errorCount}, 0);
        check("midreset instruction", instruction, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        outReady = 1'b1;
        send(tbl[1]);
        drain();

        // 257 illegal requests: counter saturates, wordIndex wraps
        repeat (257) send(tbl[14]);
        drain();
        check("errorCount saturated", {24'b0, errorCount}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset SHALL exist.
REQ-002 Ports: clk  in  1  rising-edge clock; rstn  in  1  async active-low reset.
REQ-003 Ports: inValid  in  1  request valid; inReady  out  1  request accepted when high with inValid.
REQ-004 Ports: format  in  3  0=R, 1=I (OP-IMM), 2=B, 3=J (JAL), 4=JALR, 5-7 illegal.
REQ-005 Ports: opALU  in  4  ALU code (R/I); branchT  in  3  branch fun3 (B); rd, rs1, rs2  in  5 each; immediateValue  in  32  signed byte offset or immediate.
REQ-006 Ports: instruction  out  32  encoded word; outValid  out  1; outReady  in  1; outError  out  1  word is a substituted NOP; wordIndex  out  8  sequence number of the presented word; errorCount  out  8  illegal requests seen.

Function
REQ-007 Encoding SHALL happen on acceptance; each result (word, error bit, index) SHALL be pushed into a 2-entry in-order output FIFO.
REQ-008 Latency: a request accepted at edge N into an empty FIFO SHALL be presented with outValid=1 after edge N.
REQ-009 inReady SHALL be 1 when FIFO occupancy < 2, 0 otherwise, and SHALL be independent of inValid and outReady.
REQ-010 Pop on outValid && outReady; push and pop at one edge SHALL leave occupancy unchanged; the FIFO SHALL never overflow or drop an entry.
REQ-011 outValid SHALL be 1 exactly when occupancy > 0; outputs SHALL hold stable while outValid && !outReady.
REQ-012 opALU->fun3/fun7: 0 ADD 000/0000000, 1 SUB 000/0100000, 2 AND 111, 3 OR 110, 4 XOR 100, 5 SLT 010, 6 SLTU 011, 7 SLL 001, 8 SRL 101, 9 SRA 101/0100000; unlisted fun7=0000000.
REQ-013 R: {fun7, rs2, rs1, fun3, rd, 0110011}; opALU 10-15 illegal.
REQ-014 I: {imm[11:0], rs1, fun3, rd, 0010011}; SUB and 10-15 illegal; for 7/8/9, imm[11:5] = fun7 and imm[4:0] = immediateValue[4:0].
REQ-015 JALR: {imm[11:0], rs1, 000, rd, 1100111}.
REQ-016 B: {imm[12], imm[10:5], rs2, rs1, branchT, imm[4:1], imm[11], 1100011}; branchT 2 or 3 illegal.
REQ-017 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
REQ-018 Illegal request SHALL push 0x00000013 with outError=1; legal request SHALL push outError=0.
REQ-019 errorCount SHALL increment per accepted illegal request, saturating at 255.
REQ-020 wordIndex SHALL be assigned at acceptance from an 8-bit counter wrapping 255->0, one step per accepted request (legal or illegal).

Reset
REQ-021 rstn low SHALL immediately clear occupancy, outValid=0, outError=0, instruction=0, wordIndex=0, errorCount=0; inReady SHALL read 1 while in reset.
REQ-022 Reset mid-operation SHALL discard all FIFO contents; the first request after release SHALL get wordIndex 0.

Configuration
REQ-023 Macro IMM_RANGE_CHECK_EN defined: requests with out-of-range immediates SHALL be illegal: I/JALR outside [-2048, 2047]; shifts with immediateValue[31:5] != 0; B outside [-4096, 4094] or odd; J outside [-1048576, 1048574] or odd.
REQ-024 Macro undefined: no range or alignment checks; immediates SHALL be truncated to field width, and bit 0 of B/J ignored.

Verification
REQ-025 R, opALU=0, rd=1, rs1=2, rs2=3 -> instruction 0x003100B3, outError=0, wordIndex=0.
REQ-026 I, opALU=0, rd=5, rs1=0, imm=-1 -> 0xFFF00293; B, branchT=0, rs1=1, rs2=2, imm=8 -> 0x00208463; J, rd=1, imm=2048 -> 0x001000EF.
REQ-027 I, opALU=0, rd=0, rs1=0, imm=2048 -> with macro 0x00000013, outError=1, errorCount=1; without macro 0x80000013, outError=0.
REQ-028 outReady=0, inValid=1 for 3 cycles -> 2 accepted, inReady=0 on cycle 3; outReady=1 -> words drain in order one per cycle, wordIndex 0,1,2.
REQ-029 format=6 -> 0x00000013, outError=1; 256 illegal requests -> errorCount 255.
REQ-030 rstn low with 2 words queued -> outValid=0 immediately; after release, next word wordIndex=0.
